// File: rtl/status_frame_deframer.sv
// status_frame_deframer: hunts the byte stream for the 0x1CEB00DA status magic,
// collects 17 data bytes plus a big-endian CRC16 (poly 0x8005, init 0xFFFF,
// MSB first), and publishes the decoded motor status on a one-cycle strobe.
// Optional: define STATUS_DEFRAMER_ERRCNT_EN to add saturating error counters.
module status_frame_deframer #(
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int BAUDRATE          = 2_000_000,
  parameter int BYTE_TIMEOUT_BITS = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic               frame_valid,
  output logic [7:0]         motor_id,
  output logic [7:0]         control_mode,
  output logic signed [23:0] encoder0_position,
  output logic signed [23:0] encoder1_position,
  output logic signed [23:0] setpoint_actual,
  output logic signed [23:0] duty,
  output logic signed [23:0] displacement,
  output logic               crc_error,
  output logic               timeout_error,
  output logic               busy
`ifdef STATUS_DEFRAMER_ERRCNT_EN
  ,
  output logic [15:0]        crc_error_count,
  output logic [15:0]        timeout_count
`endif
);

  localparam int TMO_CYCLES = CLK_FREQ_HZ / BAUDRATE * BYTE_TIMEOUT_BITS;
  localparam int TW         = $clog2(TMO_CYCLES + 1);
  localparam int PLW        = 19 * 8;
  localparam logic [31:0] MAGIC = 32'h1CEB00DA;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t           state_q, state_d;
  logic [31:0]      hunt_sr;
  logic [4:0]       idx_q;
  logic [15:0]      crc_q;
  logic [PLW-1:0]   pl_q;     // byte 0 ends up in the top byte after 19 shifts
  logic [TW-1:0]    tmo_q;

  logic [31:0] hunt_next;
  logic        magic_hit, last_byte, expire, crc_ok;

  // One byte of the MSB-first CRC16 (0x8005), no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign hunt_next = {hunt_sr[23:0], rx_byte};
  assign magic_hit = (state_q == HUNT) && rx_valid && (hunt_next == MAGIC);
  assign last_byte = (state_q == PAYLOAD) && rx_valid && (idx_q == 5'd18);
  // A byte arriving in the expiry cycle reloads the counter instead of failing.
  assign expire    = (state_q == PAYLOAD) && !rx_valid && (tmo_q == TW'(1));
  assign crc_ok    = (crc_q == pl_q[15:0]);
  assign busy      = (state_q != HUNT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (magic_hit) state_d = PAYLOAD;
      PAYLOAD: if (last_byte) state_d = CHECK;
               else if (expire) state_d = HUNT;
      CHECK:   state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Hunt shift register, payload capture, running CRC and inter-byte timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hunt_sr <= '0;
      idx_q   <= '0;
      crc_q   <= 16'hFFFF;
      pl_q    <= '0;
      tmo_q   <= '0;
    end else begin
      // Cleared on sync so magic bytes inside a payload can never re-trigger;
      // still shifted during CHECK so a frame directly following is caught.
      if (magic_hit)
        hunt_sr <= '0;
      else if (rx_valid && state_q != PAYLOAD)
        hunt_sr <= hunt_next;

      if (magic_hit) begin
        idx_q <= '0;
        crc_q <= 16'hFFFF;
        tmo_q <= TW'(TMO_CYCLES);
      end else if (state_q == PAYLOAD) begin
        if (rx_valid) begin
          idx_q <= idx_q + 5'd1;
          pl_q  <= {pl_q[PLW-9:0], rx_byte};
          tmo_q <= TW'(TMO_CYCLES);
          if (idx_q < 5'd17) crc_q <= crc16_byte(crc_q, rx_byte);
        end else if (tmo_q != '0) begin
          tmo_q <= tmo_q - TW'(1);
        end
      end
    end
  end

  // Result pulses and field registers; fields change only on a good frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid       <= 1'b0;
      crc_error         <= 1'b0;
      timeout_error     <= 1'b0;
      motor_id          <= '0;
      control_mode      <= '0;
      encoder0_position <= '0;
      encoder1_position <= '0;
      setpoint_actual   <= '0;
      duty              <= '0;
      displacement      <= '0;
    end else begin
      frame_valid   <= (state_q == CHECK) && crc_ok;
      crc_error     <= (state_q == CHECK) && !crc_ok;
      timeout_error <= expire;
      if (state_q == CHECK && crc_ok) begin
        motor_id          <= pl_q[151:144];
        control_mode      <= pl_q[143:136];
        encoder0_position <= pl_q[135:112];
        encoder1_position <= pl_q[111:88];
        setpoint_actual   <= pl_q[87:64];
        duty              <= pl_q[63:40];
        displacement      <= pl_q[39:16];
      end
    end
  end

`ifdef STATUS_DEFRAMER_ERRCNT_EN
  // Saturating error counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_error_count <= '0;
      timeout_count   <= '0;
    end else begin
      if (state_q == CHECK && !crc_ok && crc_error_count != 16'hFFFF)
        crc_error_count <= crc_error_count + 16'd1;
      if (expire && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_status_frame_deframer.sv
// tb_status_frame_deframer: directed plus randomized frames; expected pulses are
// queued by the stimulus side and popped by a monitor watching the DUT strobes.
module tb_status_frame_deframer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        frame_valid, crc_error, timeout_error, busy;
  logic [7:0]  motor_id, control_mode;
  logic signed [23:0] encoder0_position, encoder1_position, setpoint_actual, duty, displacement;
`ifdef STATUS_DEFRAMER_ERRCNT_EN
  logic [15:0] crc_error_count, timeout_count;
`endif

  status_frame_deframer dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_valid(frame_valid), .motor_id(motor_id), .control_mode(control_mode),
    .encoder0_position(encoder0_position), .encoder1_position(encoder1_position),
    .setpoint_actual(setpoint_actual), .duty(duty), .displacement(displacement),
    .crc_error(crc_error), .timeout_error(timeout_error), .busy(busy)
`ifdef STATUS_DEFRAMER_ERRCNT_EN
    , .crc_error_count(crc_error_count), .timeout_count(timeout_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // {frame_valid, crc_error, timeout_error}
    int          edge_n;
    logic [135:0] fields; // the 17 data bytes of the last good frame
    int          crc_cnt;
    int          tmo_cnt;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0, fails = 0;
  int           ecnt = 0;
  int           last_edge = 0;
  logic [7:0]   pay[17];
  logic [135:0] last_good = '0;
  int           m_crc = 0, m_tmo = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // CRC as polynomial remainder: (data * x^16 + 0xFFFF * x^136) mod 0x18005.
  function automatic logic [15:0] ref_crc();
    logic [151:0] v;
    for (int k = 0; k < 17; k++) v[151-8*k -: 8] = pay[k];
    v[15:0] = '0;
    v[151:136] = v[151:136] ^ 16'hFFFF;
    for (int i = 151; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h18005;
    return v[15:0];
  endfunction

  function automatic logic [135:0] pay_vec();
    logic [135:0] r;
    for (int k = 0; k < 17; k++) r[135-8*k -: 8] = pay[k];
    return r;
  endfunction

  // Entered and left at a negedge; the byte is sampled at edge ecnt+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    last_edge = ecnt + 1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_magic(input int maxgap);
    send_byte(8'h1C, $urandom_range(0, maxgap));
    send_byte(8'hEB, $urandom_range(0, maxgap));
    send_byte(8'h00, 0);
    chk("busy_before_sync", 64'(busy), 64'd0);
    send_byte(8'hDA, 0);
    chk("busy_after_sync", 64'(busy), 64'd1);
  endtask

  task automatic push(input logic [2:0] kind, input int edge_n);
    exp_t e;
    e.kind = kind; e.edge_n = edge_n; e.fields = last_good;
    e.crc_cnt = m_crc; e.tmo_cnt = m_tmo;
    sb.push_back(e);
  endtask

  // Full frame; cx corrupts the CRC, garb prefixes "1C EB", stall_at holds
  // the line idle right up to the expiry cycle after that payload index.
  task automatic send_frame(input logic [15:0] cx, input int maxgap, input bit garb,
                            input int stall_at);
    logic [15:0] c;
    c = ref_crc() ^ cx;
    if (garb) begin
      send_byte(8'h1C, $urandom_range(0, maxgap));
      send_byte(8'hEB, $urandom_range(0, maxgap));
    end
    send_magic(maxgap);
    for (int k = 0; k < 17; k++) begin
      if (k == stall_at) begin
        send_byte(pay[k], 0);
        repeat (999) @(negedge clk);
      end else begin
        send_byte(pay[k], $urandom_range(0, maxgap));
      end
    end
    send_byte(c[15:8], $urandom_range(0, maxgap));
    send_byte(c[7:0], 0);
    if (cx == 16'h0) begin
      last_good = pay_vec();
      push(3'b100, last_edge + 1);
    end else begin
      m_crc++;
      push(3'b010, last_edge + 1);
    end
  endtask

  task automatic send_stall(input int n);
    send_magic(2);
    for (int k = 0; k < n; k++) send_byte(8'($urandom), (k == n - 1) ? 0 : $urandom_range(0, 2));
    m_tmo++;
    push(3'b001, last_edge + 1000);
    repeat (1005) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pulses"}, 64'({frame_valid, crc_error, timeout_error, busy}), 64'd0);
    chk({tag, "_ids"}, 64'({motor_id, control_mode}), 64'd0);
    chk({tag, "_enc"}, 64'({$unsigned(encoder0_position), $unsigned(encoder1_position)}), 64'd0);
    chk({tag, "_sp_duty"}, 64'({$unsigned(setpoint_actual), $unsigned(duty)}), 64'd0);
    chk({tag, "_disp"}, 64'($unsigned(displacement)), 64'd0);
`ifdef STATUS_DEFRAMER_ERRCNT_EN
    chk({tag, "_counts"}, 64'({crc_error_count, timeout_count}), 64'd0);
`endif
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (frame_valid || crc_error || timeout_error)) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_pulse actual=%b%b%b required=000", frame_valid, crc_error, timeout_error);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", 64'({frame_valid, crc_error, timeout_error}), 64'(mon_e.kind));
        chk("pulse_cycle", 64'(ecnt), 64'(mon_e.edge_n));
        chk("busy_at_pulse", 64'(busy), 64'd0);
        chk("f_ids", 64'({motor_id, control_mode}), 64'(mon_e.fields[135:120]));
        chk("f_enc0", 64'($unsigned(encoder0_position)), 64'(mon_e.fields[119:96]));
        chk("f_enc1", 64'($unsigned(encoder1_position)), 64'(mon_e.fields[95:72]));
        chk("f_setpoint", 64'($unsigned(setpoint_actual)), 64'(mon_e.fields[71:48]));
        chk("f_duty", 64'($unsigned(duty)), 64'(mon_e.fields[47:24]));
        chk("f_disp", 64'($unsigned(displacement)), 64'(mon_e.fields[23:0]));
`ifdef STATUS_DEFRAMER_ERRCNT_EN
        chk("crc_error_count", 64'(crc_error_count), 64'(mon_e.crc_cnt));
        chk("timeout_count", 64'(timeout_count), 64'(mon_e.tmo_cnt));
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] base[17];
    base = '{8'h03, 8'h01, 8'h12, 8'h34, 8'h56, 8'hFE, 8'hDC, 8'hBA,
             8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h2A};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Known frame, then its corrupted twin, then a stall.
    pay = base;
    send_frame(16'h0000, 1, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("duty_is_neg128", 64'(($signed(duty) == -24'sd128)), 64'd1);
    send_frame(16'h0001, 1, 1'b0, -1);
    repeat (4) @(negedge clk);
    send_stall(5);

    // Garbage "1C EB" before the real magic.
    pay = base; pay[0] = 8'h07;
    send_frame(16'h0000, 0, 1'b1, -1);
    repeat (3) @(negedge clk);

    // Magic embedded in the payload data.
    pay = base; pay[3] = 8'h1C; pay[4] = 8'hEB; pay[5] = 8'h00; pay[6] = 8'hDA;
    send_frame(16'h0000, 2, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Byte arrives in the very cycle the timer would expire.
    pay = base; pay[1] = 8'h02;
    send_frame(16'h0000, 1, 1'b0, 4);
    repeat (3) @(negedge clk);

    // Reset after payload byte 10, then a clean frame.
    send_magic(1);
    for (int k = 0; k <= 10; k++) send_byte(8'($urandom), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    chk("sb_empty_at_reset", 64'(sb.size()), 64'd0);
    last_good = '0; m_crc = 0; m_tmo = 0;
    reset = 1'b0;
    @(negedge clk);
    pay = base; pay[16] = 8'h55;
    send_frame(16'h0000, 1, 1'b0, -1);

    // Randomized mix, including back-to-back frames.
    for (int it = 0; it < 40; it++) begin
      int typ;
      typ = $urandom_range(0, 9);
      for (int k = 0; k < 17; k++) pay[k] = 8'($urandom);
      if (typ == 8) begin
        send_stall($urandom_range(0, 18));
      end else begin
        if (typ == 9)
          for (int g = $urandom_range(1, 4); g > 0; g--) begin
            logic [7:0] gb;
            gb = 8'($urandom);
            if (gb == 8'h1C) gb = 8'h1D;
            send_byte(gb, $urandom_range(0, 2));
          end
        if (typ == 6 || typ == 7)
          send_frame(16'($urandom_range(1, 16'hFFFF)), $urandom_range(0, 3), 1'b0, -1);
        else
          send_frame(16'h0000, $urandom_range(0, 3), 1'b0, -1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
